obstacle_scroller: RTL
======================

# obstacle_scroller

Upstream pixel engine for the helicopter game's scrolling obstacle column; it is one of the two engines feeding the display multiplexer ahead of the VGA adapter. On each `go` pulse it erases the column at its current position, moves it one pixel left, and redraws it with a vertical flight gap. It emits one pixel per clock as `x`/`y`/`color`/`plot`. `done` is high whenever the engine is not driving pixels.

## Interface
- `W`, 4: obstacle width in pixels, 1..16.
- `H`, 120: screen height, i.e. rows scanned per phase.
- `SCREEN_W`, 160: screen width; pixels with x ≥ `SCREEN_W` are suppressed.
- `GAP_H`, 30: gap height in rows, 1..`H`-1.
- `START_X`, 159: column position after reset and after wrap.
- `RESET_GAP`, 40: gap top row after reset.

- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-low.
- `go`, in, 1: start one erase/move/draw frame; level sampled in IDLE.
- `freeze`, in, 1: crash hold; while high, `go` is ignored and a frame already running completes.
- `gap_y`, in, 7: requested gap top row; latched only on wrap.
- `color_in`, in, 3: obstacle colour.
- `x`, out, 8: pixel column.
- `y`, out, 7: pixel row.
- `color`, out, 3: pixel colour.
- `plot`, out, 1: pixel write enable.
- `done`, out, 1: 1 = idle/finished, 0 = busy.

## Operation
- State: `pos` (8b, left column of obstacle), `gap_r` (7b), `col` (4b), `row` (7b), FSM {IDLE, ERASE, MOVE, DRAW}.
- Reset (`reset`=0 at an edge):
  - state → IDLE, `pos` → `START_X`, `gap_r` → `RESET_GAP`, `col`=`row`=0.
  - `x`=0, `y`=0, `color`=000, `plot`=0, `done`=1.
  - Applies mid-frame: the frame is aborted with no further plots.
- IDLE: `plot`=0, `done`=1. `go`=1 & `freeze`=0 → ERASE with `col`=`row`=0.
- ERASE: scans W×H pixels, `col` fastest (0..W-1), then `row` (0..H-1).
  - `x`=`pos`+`col`, `y`=`row`, `color`=000.
  - `plot`=1 unless (`pos`+`col`) ≥ `SCREEN_W`, computed 9-bit.
  - Suppressed pixels still take one cycle.
  - The last pixel (`col`=W-1, `row`=H-1) is followed by MOVE.
- MOVE (1 cycle, `plot`=0):
  - `pos` = `pos`-1.
  - If `pos`==0: `pos` ← `START_X` and `gap_r` ← min(`gap_y`, H-`GAP_H`).
  - → DRAW, with counters cleared.
- DRAW: same scan and suppression as ERASE.
  - `color` = 000 when `gap_r` ≤ `row` < `gap_r`+`GAP_H`, else `color_in`.
  - After the last pixel → IDLE.
- `go` during ERASE/MOVE/DRAW is ignored; no queuing.
- `freeze` rising mid-frame does not abort the frame.
- All outputs are registered; `x`/`y`/`color` hold their last values when `plot`=0 in IDLE.

## Timing
- `go` sampled at edge E0. From the cycle after E0:
  - ERASE pixels occupy W×H consecutive cycles.
  - MOVE occupies 1 cycle.
  - DRAW pixels occupy W×H cycles.
  - `done`=1 from the next cycle onward.
- `done` is low for exactly 2·W·H+1 cycles. With default parameters that is 961 cycles: 480 erase + 1 move + 480 draw.
- Throughput: one pixel per clock; `plot` has no gaps inside a phase except for suppressed pixels.
- `go` held high continuously starts a new frame on the first cycle `done`=1 is sampled in IDLE. That gives 1 idle cycle between frames.
- Reset has priority over every other input at the same edge.

## Test plan
- Reset, then idle 5 cycles:
  - `done`=1, `plot`=0, `x`=0, `y`=0, `color`=000.
  - First `go` erases at `pos`=159: only `x`=159 plots, x=160..162 are suppressed.
- Default params, `pos`=100, `gap_r`=40, `color_in`=100, one-cycle `go`:
  - 480 erase pixels, `color` 000, covering x 100..103 and y 0..119.
  - 1 MOVE cycle with `plot`=0.
  - 480 draw pixels at x 99..102; rows 40..69 are 000, all other rows are 100.
  - `done` low for exactly 961 cycles.
- Wrap: `pos`=0, `gap_y`=110, `go`:
  - Next frame draws at x 159 only.
  - `gap_r`=90 (clamped); rows 90..119 are black.
- `go` pulsed at cycle 200 of a frame and held through it: no restart until the frame ends; the next frame begins after 1 idle cycle.
- `freeze`=1 at cycle 300 of a frame: the frame completes; a subsequent `go` is ignored and `done` stays 1.
- `reset`=0 at DRAW cycle 50:
  - Next cycle: `plot`=0, `done`=1, `pos`=159, `gap_r`=40.
  - No further pixels are emitted.

Source files
------------

// File: rtl/obstacle_scroller.sv
// -----------------------------------------------------------------------------
// obstacle_scroller
//
// Pixel engine for the scrolling obstacle column of the helicopter game. Each
// accepted `go` runs one frame: erase the column at its current position,
// step it one pixel left (wrapping to START_X and picking up a new gap after
// column 0), then redraw it with a black vertical flight gap. One pixel is
// emitted per clock.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-low; aborts any frame in progress
//   go        in   start a frame (sampled only while idle)
//   freeze    in   crash hold; blocks new frames, never aborts a running one
//   gap_y     in   requested gap top row, taken only when the column wraps
//   color_in  in   obstacle colour
//   x, y      out  pixel coordinates
//   color     out  pixel colour
//   plot      out  pixel write enable
//   done      out  1 while idle, 0 while a frame is running
//
// Handshake: `go` is a level request, accepted on any edge where the engine
// is idle (done=1), freeze=0 and reset=1; it is not queued while busy.
// -----------------------------------------------------------------------------
module obstacle_scroller #(
   parameter int W         = 4,
   parameter int H         = 120,
   parameter int SCREEN_W  = 160,
   parameter int GAP_H     = 30,
   parameter int START_X   = 159,
   parameter int RESET_GAP = 40
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic       freeze,
   input  logic [6:0] gap_y,
   input  logic [2:0] color_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] color,
   output logic       plot,
   output logic       done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ERASE = 2'd1;
   localparam logic [1:0] S_MOVE  = 2'd2;
   localparam logic [1:0] S_DRAW  = 2'd3;

   localparam logic [3:0] COL_LAST   = 4'(W - 1);
   localparam logic [6:0] ROW_LAST   = 7'(H - 1);
   localparam logic [7:0] START_POS  = 8'(START_X);
   localparam logic [6:0] GAP_MAX    = 7'(H - GAP_H);
   localparam logic [6:0] GAP_RST    = 7'(RESET_GAP);
   localparam logic [8:0] SCREEN_LIM = 9'(SCREEN_W);
   localparam logic [7:0] GAP_SPAN   = 8'(GAP_H);

   logic [1:0] state, state_n;
   logic [7:0] pos, pos_n;
   logic [6:0] gap_r, gap_n;
   logic [3:0] col, col_n;
   logic [6:0] row, row_n;

   logic       last_pix;
   logic [8:0] px_n;
   logic       in_gap_n;
   logic       pixel_n;

   // Next-state logic. The output registers are loaded from the *next*
   // state/counter values so that the pixel belonging to a state appears in
   // the same cycle that state is current.
   always_comb begin
      state_n  = state;
      pos_n    = pos;
      gap_n    = gap_r;
      col_n    = col;
      row_n    = row;
      last_pix = (col == COL_LAST) && (row == ROW_LAST);
      case (state)
         S_IDLE: begin
            if (go && !freeze) begin
               state_n = S_ERASE;
               col_n   = 4'd0;
               row_n   = 7'd0;
            end
         end
         S_ERASE, S_DRAW: begin
            if (last_pix) begin
               state_n = (state == S_ERASE) ? S_MOVE : S_IDLE;
               col_n   = 4'd0;
               row_n   = 7'd0;
            end else if (col == COL_LAST) begin
               col_n = 4'd0;
               row_n = row + 7'd1;
            end else begin
               col_n = col + 4'd1;
            end
         end
         S_MOVE: begin
            state_n = S_DRAW;
            col_n   = 4'd0;
            row_n   = 7'd0;
            // Wrap is decided on the position just erased: column 0 is
            // erased, then the column reappears at the right edge.
            if (pos == 8'd0) begin
               pos_n = START_POS;
               gap_n = (gap_y > GAP_MAX) ? GAP_MAX : gap_y;
            end else begin
               pos_n = pos - 8'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // 9-bit sum so columns past the right screen edge are detected rather
   // than wrapping around to the left.
   assign px_n     = {1'b0, pos_n} + {5'd0, col_n};
   assign in_gap_n = (row_n >= gap_n) && ({1'b0, row_n} < ({1'b0, gap_n} + GAP_SPAN));
   assign pixel_n  = (state_n == S_ERASE) || (state_n == S_DRAW);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
         pos   <= START_POS;
         gap_r <= GAP_RST;
         col   <= 4'd0;
         row   <= 7'd0;
         x     <= 8'd0;
         y     <= 7'd0;
         color <= 3'b000;
         plot  <= 1'b0;
         done  <= 1'b1;
      end else begin
         state <= state_n;
         pos   <= pos_n;
         gap_r <= gap_n;
         col   <= col_n;
         row   <= row_n;
         plot  <= pixel_n && (px_n < SCREEN_LIM);
         done  <= (state_n == S_IDLE);
         // Coordinates advance even for suppressed pixels; they hold
         // through MOVE and IDLE.
         if (pixel_n) begin
            x     <= px_n[7:0];
            y     <= row_n;
            color <= ((state_n == S_DRAW) && !in_gap_n) ? color_in : 3'b000;
         end
      end
   end

endmodule
